// File: rtl/seq_enum.sv
// rtl/seq_enum.sv - enumerates a run of sequence words into the calc_e_buf valid/ready handshake
// One beat per cycle while i_ready is high; the run ends on count exhaustion or abort.
module seq_enum #(
   parameter int SEQ_WIDTH = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_start,
   input  logic                 i_abort,
   input  logic [SEQ_WIDTH-1:0] i_first,
   input  logic [CNT_WIDTH-1:0] i_count,
   input  logic [SEQ_WIDTH-1:0] i_mask,
   output logic [SEQ_WIDTH-1:0] o_seq,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [CNT_WIDTH-1:0] o_issued
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [SEQ_WIDTH-1:0] r_cur;
   logic [SEQ_WIDTH-1:0] w_cur_nxt;
   logic [CNT_WIDTH-1:0] r_remaining;
   logic [CNT_WIDTH-1:0] w_remaining_nxt;
   logic [CNT_WIDTH-1:0] r_issued;
   logic [CNT_WIDTH-1:0] w_issued_nxt;
   logic                 w_xfer;
   logic                 w_last;

   assign w_xfer = (r_state == ST_RUN) && i_ready;
   assign w_last = (r_remaining == CNT_WIDTH'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cur       <= '0;
         r_remaining <= '0;
         r_issued    <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cur       <= w_cur_nxt;
         r_remaining <= w_remaining_nxt;
         r_issued    <= w_issued_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cur_nxt       = r_cur;
      w_remaining_nxt = r_remaining;
      w_issued_nxt    = r_issued;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_issued_nxt = '0;
               if (i_count != '0) begin
                  w_cur_nxt       = i_first;
                  w_remaining_nxt = i_count;
                  w_state_nxt     = ST_RUN;
               end else begin
                  w_state_nxt = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            // the enumeration steps the full word; i_mask only shapes the output
            if (w_xfer) begin
               w_cur_nxt       = r_cur + SEQ_WIDTH'(1);
               w_remaining_nxt = r_remaining - CNT_WIDTH'(1);
               w_issued_nxt    = r_issued + CNT_WIDTH'(1);
            end
            if ((w_xfer && w_last) || i_abort) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign o_valid  = (r_state == ST_RUN);
   assign o_seq    = o_valid ? (r_cur & i_mask) : '0;
   assign o_busy   = (r_state != ST_IDLE);
   assign o_done   = (r_state == ST_DONE);
   assign o_issued = r_issued;

endmodule

// File: tb/tb_seq_enum.sv
// tb/tb_seq_enum.sv - directed vector table plus hand-written backpressure/mask sequence for seq_enum
module tb_seq_enum;

   logic        clk;
   logic        rst;
   logic        i_start;
   logic        i_abort;
   logic [7:0]  i_first;
   logic [15:0] i_count;
   logic [7:0]  i_mask;
   logic [7:0]  o_seq;
   logic        o_valid;
   logic        i_ready;
   logic        o_busy;
   logic        o_done;
   logic [15:0] o_issued;

   int checks;
   int errors;

   seq_enum #(.SEQ_WIDTH(8), .CNT_WIDTH(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .i_start  (i_start),
      .i_abort  (i_abort),
      .i_first  (i_first),
      .i_count  (i_count),
      .i_mask   (i_mask),
      .o_seq    (o_seq),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_busy   (o_busy),
      .o_done   (o_done),
      .o_issued (o_issued)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        start;
      logic        abort;
      logic        ready;
      logic [7:0]  first;
      logic [15:0] count;
      logic [7:0]  mask;
      logic        e_valid;
      logic [7:0]  e_seq;
      logic        e_busy;
      logic        e_done;
      logic [15:0] e_issued;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic r, input logic s, input logic a, input logic rdy,
                               input logic [7:0] first, input logic [15:0] count, input logic [7:0] mask,
                               input logic ev, input logic [7:0] eseq, input logic eb, input logic ed,
                               input logic [15:0] eiss);
      vec_t v;
      v.rst = r; v.start = s; v.abort = a; v.ready = rdy;
      v.first = first; v.count = count; v.mask = mask;
      v.e_valid = ev; v.e_seq = eseq; v.e_busy = eb; v.e_done = ed; v.e_issued = eiss;
      tbl.push_back(v);
   endfunction

   task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s [%0d] got %0h expected %0h", name, idx, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_ready = 1'b0;
      i_first = 8'h00; i_count = 16'd0; i_mask = 8'hFF;
      repeat (3) @(posedge clk);

      //  rst s a rdy first  count   mask   | valid seq  busy done issued
      // reset state
      add(0,0,0,0, 8'h00, 16'd0,   8'hFF,  0, 8'h00, 0,0, 16'd0);
      // sequential wrap FE..01
      add(0,1,0,1, 8'hFE, 16'd4,   8'hFF,  0, 8'h00, 0,0, 16'd0);
      add(0,0,0,1, 8'h00, 16'd0,   8'hFF,  1, 8'hFE, 1,0, 16'd0);
      add(0,0,0,1, 8'h00, 16'd0,   8'hFF,  1, 8'hFF, 1,0, 16'd1);
      add(0,0,0,1, 8'h00, 16'd0,   8'hFF,  1, 8'h00, 1,0, 16'd2);
      add(0,0,0,1, 8'h00, 16'd0,   8'hFF,  1, 8'h01, 1,0, 16'd3);
      add(0,0,0,1, 8'h00, 16'd0,   8'hFF,  0, 8'h00, 1,1, 16'd4);
      add(0,0,0,1, 8'h00, 16'd0,   8'hFF,  0, 8'h00, 0,0, 16'd4);
      // backpressure, ready toggling 0/1
      add(0,1,0,0, 8'h10, 16'd3,   8'hFF,  0, 8'h00, 0,0, 16'd4);
      add(0,0,0,0, 8'h00, 16'd0,   8'hFF,  1, 8'h10, 1,0, 16'd0);
      add(0,0,0,1, 8'h00, 16'd0,   8'hFF,  1, 8'h10, 1,0, 16'd0);
      add(0,0,0,0, 8'h00, 16'd0,   8'hFF,  1, 8'h11, 1,0, 16'd1);
      add(0,0,0,1, 8'h00, 16'd0,   8'hFF,  1, 8'h11, 1,0, 16'd1);
      add(0,0,0,0, 8'h00, 16'd0,   8'hFF,  1, 8'h12, 1,0, 16'd2);
      add(0,0,0,1, 8'h00, 16'd0,   8'hFF,  1, 8'h12, 1,0, 16'd2);
      add(0,0,0,0, 8'h00, 16'd0,   8'hFF,  0, 8'h00, 1,1, 16'd3);
      add(0,0,0,0, 8'h00, 16'd0,   8'hFF,  0, 8'h00, 0,0, 16'd3);
      // zero count goes straight to DONE
      add(0,1,0,1, 8'h55, 16'd0,   8'hFF,  0, 8'h00, 0,0, 16'd3);
      add(0,0,0,1, 8'h00, 16'd0,   8'hFF,  0, 8'h00, 1,1, 16'd0);
      add(0,0,0,1, 8'h00, 16'd0,   8'hFF,  0, 8'h00, 0,0, 16'd0);
      // mask 0F, start during RUN/DONE and abort in IDLE ignored
      add(0,1,0,1, 8'h1E, 16'd3,   8'h0F,  0, 8'h00, 0,0, 16'd0);
      add(0,1,0,1, 8'h40, 16'd9,   8'h0F,  1, 8'h0E, 1,0, 16'd0);
      add(0,1,0,1, 8'h40, 16'd9,   8'h0F,  1, 8'h0F, 1,0, 16'd1);
      add(0,0,0,1, 8'h00, 16'd0,   8'h0F,  1, 8'h00, 1,0, 16'd2);
      add(0,1,1,1, 8'h40, 16'd0,   8'h0F,  0, 8'h00, 1,1, 16'd3);
      add(0,0,1,1, 8'h00, 16'd0,   8'hFF,  0, 8'h00, 0,0, 16'd3);
      add(0,0,0,1, 8'h00, 16'd0,   8'hFF,  0, 8'h00, 0,0, 16'd3);
      // abort on the 5th transfer
      add(0,1,0,1, 8'h00, 16'd100, 8'hFF,  0, 8'h00, 0,0, 16'd3);
      add(0,0,0,1, 8'h00, 16'd0,   8'hFF,  1, 8'h00, 1,0, 16'd0);
      add(0,0,0,1, 8'h00, 16'd0,   8'hFF,  1, 8'h01, 1,0, 16'd1);
      add(0,0,0,1, 8'h00, 16'd0,   8'hFF,  1, 8'h02, 1,0, 16'd2);
      add(0,0,0,1, 8'h00, 16'd0,   8'hFF,  1, 8'h03, 1,0, 16'd3);
      add(0,0,1,1, 8'h00, 16'd0,   8'hFF,  1, 8'h04, 1,0, 16'd4);
      add(0,0,0,1, 8'h00, 16'd0,   8'hFF,  0, 8'h00, 1,1, 16'd5);
      add(0,0,0,1, 8'h00, 16'd0,   8'hFF,  0, 8'h00, 0,0, 16'd5);
      add(0,0,0,1, 8'h00, 16'd0,   8'hFF,  0, 8'h00, 0,0, 16'd5);
      // reset mid-run after 2 of 10 transfers, colliding with start and ready
      add(0,1,0,1, 8'h00, 16'd10,  8'hFF,  0, 8'h00, 0,0, 16'd5);
      add(0,0,0,1, 8'h00, 16'd0,   8'hFF,  1, 8'h00, 1,0, 16'd0);
      add(0,0,0,1, 8'h00, 16'd0,   8'hFF,  1, 8'h01, 1,0, 16'd1);
      add(1,1,1,1, 8'h00, 16'd5,   8'hFF,  1, 8'h02, 1,0, 16'd2);
      add(0,0,0,1, 8'h00, 16'd0,   8'hFF,  0, 8'h00, 0,0, 16'd0);
      add(0,0,0,1, 8'h00, 16'd0,   8'hFF,  0, 8'h00, 0,0, 16'd0);

      foreach (tbl[i]) begin
         step();
         rst     = tbl[i].rst;
         i_start = tbl[i].start;
         i_abort = tbl[i].abort;
         i_ready = tbl[i].ready;
         i_first = tbl[i].first;
         i_count = tbl[i].count;
         i_mask  = tbl[i].mask;
         #3;
         check("valid",  i, 32'(o_valid),  32'(tbl[i].e_valid));
         check("seq",    i, 32'(o_seq),    32'(tbl[i].e_seq));
         check("busy",   i, 32'(o_busy),   32'(tbl[i].e_busy));
         check("done",   i, 32'(o_done),   32'(tbl[i].e_done));
         check("issued", i, 32'(o_issued), 32'(tbl[i].e_issued));
      end

      // long stall: value must hold and o_seq must follow i_mask combinationally
      step();
      rst = 1'b0; i_start = 1'b1; i_abort = 1'b0; i_ready = 1'b0;
      i_first = 8'h80; i_count = 16'd2; i_mask = 8'hFF;
      step();
      i_start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #3;
         check("stall_valid", k, 32'(o_valid), 32'd1);
         check("stall_seq",   k, 32'(o_seq),   32'h80);
         step();
      end
      i_mask = 8'h0F;
      #3;
      check("mask_comb", 0, 32'(o_seq), 32'h00);
      i_mask = 8'hC0;
      #1;
      check("mask_comb", 1, 32'(o_seq), 32'h80);
      step();
      i_mask = 8'hFF;
      i_ready = 1'b1;
      #3;
      check("stall_issued", 0, 32'(o_issued), 32'd0);
      step();
      #3;
      check("second_seq", 0, 32'(o_seq), 32'h81);
      begin
         int  n;
         logic seen;
         seen = 1'b0;
         for (n = 0; n < 6 && !seen; n++) begin
            step();
            #3;
            if (o_done) seen = 1'b1;
         end
         checks++;
         if (!seen) begin
            errors++;
            $display("FAIL done_timeout got o_done 0 expected 1 within 6 cycles");
         end
         check("final_issued", 0, 32'(o_issued), 32'd2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
